// File: rtl/ex_div_if.sv
// ex_div_if: EX-stage <-> divide sequencer handshake and operand bus.
// The master modport is the EX side and the slave modport is the divider.
`timescale 1ns/1ps
interface ex_div_if #(
  parameter int DATA_W = 32
);
  logic                start_i;
  logic                annul_i;
  logic                signed_i;
  logic [DATA_W-1:0]   opdata1_i;
  logic [DATA_W-1:0]   opdata2_i;
  logic [2*DATA_W-1:0] result_o;
  logic                ready_o;
  logic                stall_req_o;

  modport master (
    output start_i, annul_i, signed_i, opdata1_i, opdata2_i,
    input  result_o, ready_o, stall_req_o
  );

  modport slave (
    input  start_i, annul_i, signed_i, opdata1_i, opdata2_i,
    output result_o, ready_o, stall_req_o
  );
endinterface

// File: rtl/ex_div_seq.sv
// ex_div_seq: multi-cycle restoring shift-subtract divider for DIV/DIVU.
// result_o = {remainder, quotient}. Synchronous active-high reset (rst).
// Optional macro DIV_EARLY_OUT_EN: finishes in two edges when the dividend
// magnitude is below the divisor magnitude (quotient 0, remainder = dividend).
`timescale 1ns/1ps
module ex_div_seq #(
  parameter int DATA_W = 32
) (
  input  logic     clk,
  input  logic     rst,
  ex_div_if.slave  bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   quo;
  logic [DATA_W-1:0]   rem;
  logic [DATA_W-1:0]   divisor;
  logic                neg_quo;
  logic                neg_rem;
  logic [2*DATA_W-1:0] result;
  logic                ready;

  logic                op1_neg;
  logic                op2_neg;
  logic [DATA_W-1:0]   op1_mag;
  logic [DATA_W-1:0]   op2_mag;
  logic                accept;
  logic [DATA_W:0]     shifted;
  logic                fits;
  logic [DATA_W-1:0]   rem_sub;
  logic [DATA_W-1:0]   quo_fix;
  logic [DATA_W-1:0]   rem_fix;
  logic                steps_done;

`ifdef DIV_EARLY_OUT_EN
  logic                early;
  logic [DATA_W-1:0]   early_rem;
`endif

  // Operand magnitudes, one restoring step and final sign correction.
  always_comb begin
    op1_neg    = bus.signed_i & bus.opdata1_i[DATA_W-1];
    op2_neg    = bus.signed_i & bus.opdata2_i[DATA_W-1];
    op1_mag    = op1_neg ? (~bus.opdata1_i + 1'b1) : bus.opdata1_i;
    op2_mag    = op2_neg ? (~bus.opdata2_i + 1'b1) : bus.opdata2_i;
    accept     = bus.start_i & ~bus.annul_i;
    shifted    = {rem, quo[DATA_W-1]};
    fits       = (shifted >= {1'b0, divisor});
    rem_sub    = shifted[DATA_W-1:0] - divisor;
    quo_fix    = neg_quo ? (~quo + 1'b1) : quo;
    rem_fix    = neg_rem ? (~rem + 1'b1) : rem;
    steps_done = (cnt == CNT_W'(DATA_W));
`ifdef DIV_EARLY_OUT_EN
    early_rem  = neg_rem ? (~quo + 1'b1) : quo;
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= FREE;
    else     state <= state_next;
  end

  // Next-state decode and the combinational stall request.
  always_comb begin
    state_next      = state;
    bus.stall_req_o = (bus.start_i & (state != END)) | (state == ON) | (state == BYZERO);
    case (state)
      FREE: begin
        if (accept) begin
          if (bus.opdata2_i == '0) state_next = BYZERO;
          else                     state_next = ON;
        end
      end
      BYZERO: state_next = END;
      ON: begin
        if (bus.annul_i) state_next = FREE;
`ifdef DIV_EARLY_OUT_EN
        else if (early)  state_next = END;
`endif
        else if (steps_done) state_next = END;
      end
      END: begin
        if (!bus.start_i) state_next = FREE;
      end
      default: state_next = FREE;
    endcase
  end

  // Datapath: operand latch, iteration, result load and release.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      quo     <= '0;
      rem     <= '0;
      divisor <= '0;
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
      result  <= '0;
      ready   <= 1'b0;
`ifdef DIV_EARLY_OUT_EN
      early   <= 1'b0;
`endif
    end else begin
      case (state)
        FREE: begin
          if (accept && (bus.opdata2_i != '0)) begin
            cnt     <= '0;
            rem     <= '0;
            quo     <= op1_mag;
            divisor <= op2_mag;
            neg_quo <= op1_neg ^ op2_neg;
            neg_rem <= op1_neg;
`ifdef DIV_EARLY_OUT_EN
            early   <= (op1_mag < op2_mag);
`endif
          end
        end
        BYZERO: begin
          result <= '0;
          ready  <= 1'b1;
        end
        ON: begin
          if (bus.annul_i) begin
            ready <= 1'b0;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (early) begin
            result <= {early_rem, {DATA_W{1'b0}}};
            ready  <= 1'b1;
          end
`endif
          else if (!steps_done) begin
            rem <= fits ? rem_sub : shifted[DATA_W-1:0];
            quo <= {quo[DATA_W-2:0], fits};
            cnt <= cnt + 1'b1;
          end else begin
            result <= {rem_fix, quo_fix};
            ready  <= 1'b1;
          end
        end
        END: begin
          if (!bus.start_i) begin
            result <= '0;
            ready  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result_o = result;
  assign bus.ready_o  = ready;

endmodule
